ex_stage: RTL

Execute stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX register. It does ALU-control decode, forwarding-operand selection, the ALU, branch-target and destination-register selection, and it owns the EX/MEM pipeline register feeding the memory stage. With `MULT_EN` it also contains a 32-cycle iterative multiplier that stalls the front end while it runs.

---
 rtl/ex_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with forwarding, ALU and EX/MEM register.
// Define EX_STAGE_MULT_EN to build the 32-cycle iterative multiplier.
module ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IDEX_PCPlus4,
    input  logic [31:0] IDEX_readData1,
    input  logic [31:0] IDEX_readData2,
    input  logic [31:0] IDEX_signextended,
    input  logic [4:0]  IDEX_rs,
    input  logic [4:0]  IDEX_rt,
    input  logic [4:0]  IDEX_rd,
    input  logic [1:0]  IDEX_wb,
    input  logic [2:0]  IDEX_m,
    input  logic [4:0]  IDEX_ex,
    input  logic        MEMWB_regWrite,
    input  logic [4:0]  MEMWB_rd,
    input  logic [31:0] MEMWB_writeData,
    output logic [31:0] EXMEM_branchTarget,
    output logic        EXMEM_zero,
    output logic [31:0] EXMEM_aluResult,
    output logic [31:0] EXMEM_writeData,
    output logic [4:0]  EXMEM_rd,
    output logic [1:0]  EXMEM_wb,
    output logic [2:0]  EXMEM_m,
    output logic        stall
);
    logic [31:0] fwd_a, fwd_b, op_b, base_result, alu_result;
    logic [2:0]  aluop;
    logic [5:0]  funct;
    logic [3:0]  code;
    logic        is_mult;

    assign aluop = IDEX_ex[3:1];
    assign funct = IDEX_signextended[5:0];
    assign is_mult = (aluop == 3'b010) && (funct == 6'b011000);

    // EX/MEM result outranks MEM/WB; register 0 is never forwarded
    assign fwd_a = (EXMEM_wb[1] && EXMEM_rd != 5'd0 && EXMEM_rd == IDEX_rs) ? EXMEM_aluResult :
                   (MEMWB_regWrite && MEMWB_rd != 5'd0 && MEMWB_rd == IDEX_rs) ? MEMWB_writeData :
                   IDEX_readData1;
    assign fwd_b = (EXMEM_wb[1] && EXMEM_rd != 5'd0 && EXMEM_rd == IDEX_rt) ? EXMEM_aluResult :
                   (MEMWB_regWrite && MEMWB_rd != 5'd0 && MEMWB_rd == IDEX_rt) ? MEMWB_writeData :
                   IDEX_readData2;
    assign op_b = IDEX_ex[4] ? IDEX_signextended : fwd_b;

    // R-type funct is folded onto the direct ALUOp codes; 4'b1110 is sll, 4'b1111 invalid
    assign code = (aluop != 3'b010)        ? {1'b0, aluop} :
                  (funct == 6'b100000)     ? 4'd0 :
                  (funct == 6'b100010)     ? 4'd1 :
                  (funct == 6'b100100)     ? 4'd3 :
                  (funct == 6'b100101)     ? 4'd4 :
                  (funct == 6'b101010)     ? 4'd5 :
                  (funct == 6'b000000)     ? 4'd14 : 4'd15;

    assign base_result = (code == 4'd0)  ? fwd_a + op_b :
                         (code == 4'd1)  ? fwd_a - op_b :
                         (code == 4'd3)  ? fwd_a & op_b :
                         (code == 4'd4)  ? fwd_a | op_b :
                         (code == 4'd5)  ? {31'd0, $signed(fwd_a) < $signed(op_b)} :
                         (code == 4'd14) ? op_b << IDEX_signextended[10:6] : 32'd0;

`ifdef EX_STAGE_MULT_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state, state_next;
    logic [31:0] mul_a, mul_b, acc;
    logic [4:0]  cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && is_mult) begin
                mul_a <= fwd_a;
                mul_b <= op_b;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == BUSY) begin
                acc <= acc + (mul_b[cnt] ? mul_a << cnt : 32'd0);
                cnt <= cnt + 5'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        stall = 1'b0;
        case (state)
            IDLE: begin
                stall = is_mult;
                state_next = is_mult ? BUSY : IDLE;
            end
            BUSY: begin
                stall = 1'b1;
                state_next = (cnt == 5'd31) ? DONE : BUSY;
            end
            default: state_next = IDLE;
        endcase
    end

    assign alu_result = (state == DONE) ? acc : base_result;
`else
    assign stall = 1'b0;
    assign alu_result = base_result;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset || stall) begin
            EXMEM_branchTarget <= '0;
            EXMEM_zero         <= 1'b0;
            EXMEM_aluResult    <= '0;
            EXMEM_writeData    <= '0;
            EXMEM_rd           <= '0;
            EXMEM_wb           <= '0;
            EXMEM_m            <= '0;
        end else begin
            EXMEM_branchTarget <= IDEX_PCPlus4 + (IDEX_signextended << 2);
            EXMEM_zero         <= (alu_result == 32'd0);
            EXMEM_aluResult    <= alu_result;
            EXMEM_writeData    <= fwd_b;
            EXMEM_rd           <= IDEX_ex[0] ? IDEX_rd : IDEX_rt;
            EXMEM_wb           <= IDEX_wb;
            EXMEM_m            <= IDEX_m;
        end
    end
endmodule
